recovery_request_arbiter: RTL and testbench

RECOVERY_REQUEST_ARBITER -- requirements
Module: recovery_request_arbiter

---
 rtl/recovery_request_arbiter_pkg.sv | 35 +++
 rtl/recovery_age_compare.sv | 19 +
 rtl/recovery_request_arbiter.sv | 137 +++++++++++++
 tb/tb_recovery_request_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recovery_request_arbiter_pkg.sv
// Shared types for the recovery request arbiter.
// Widths follow the ActiveList / address / branch-history paths.
package recovery_request_arbiter_pkg;

  localparam int ACTIVE_LIST_ENTRY_NUM = 64;
  localparam int ACTIVE_LIST_INDEX_WIDTH =
    $clog2(ACTIVE_LIST_ENTRY_NUM);
  localparam int ADDR_WIDTH = 32;
  localparam int BRANCH_GLOBAL_HISTORY_WIDTH = 10;
  localparam int REFETCH_TYPE_WIDTH = 3;

  localparam logic [7:0] DROP_COUNT_MAX = 8'hFF;

  typedef logic [ACTIVE_LIST_INDEX_WIDTH-1:0]
    ActiveListIndexPath;
  typedef logic [ADDR_WIDTH-1:0] AddrPath;
  typedef logic [BRANCH_GLOBAL_HISTORY_WIDTH-1:0]
    BranchGlobalHistoryPath;
  typedef logic [REFETCH_TYPE_WIDTH-1:0] RefetchType;

  typedef enum logic [1:0] {
    RECOVERY_ARB_IDLE,
    RECOVERY_ARB_HOLD,
    RECOVERY_ARB_ISSUED
  } RecoveryArbState;

  typedef struct packed {
    logic                   fromRw;
    RefetchType             refetchType;
    AddrPath                pc;
    BranchGlobalHistoryPath brHistory;
    ActiveListIndexPath     alPtr;
  } RecoveryReq;

endpackage

// File: rtl/recovery_age_compare.sv
// Age order of two ActiveList pointers relative to the head.
// Distance wraps naturally at index width (entry count is 2^n).
module recovery_age_compare
  import recovery_request_arbiter_pkg::*;
(
  input  logic [ACTIVE_LIST_INDEX_WIDTH-1:0] aPtr,
  input  logic [ACTIVE_LIST_INDEX_WIDTH-1:0] bPtr,
  input  logic [ACTIVE_LIST_INDEX_WIDTH-1:0] headPtr,
  output logic                               aOlder
);

  logic [ACTIVE_LIST_INDEX_WIDTH-1:0] w_distA;
  logic [ACTIVE_LIST_INDEX_WIDTH-1:0] w_distB;

  assign w_distA = aPtr - headPtr;
  assign w_distB = bPtr - headPtr;
  assign aOlder  = w_distA < w_distB;

endmodule

// File: rtl/recovery_request_arbiter.sv
// Merges CommitStage and RwStage recovery requests into one
// held request for the RecoveryManager; oldest request wins.
module recovery_request_arbiter
  import recovery_request_arbiter_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   commitReqValid,
  input  logic [REFETCH_TYPE_WIDTH-1:0]          commitRefetchType,
  input  logic [ADDR_WIDTH-1:0]                  commitPC,
  input  logic [BRANCH_GLOBAL_HISTORY_WIDTH-1:0] commitBrHistory,
  input  logic                                   rwReqValid,
  input  logic [ACTIVE_LIST_INDEX_WIDTH-1:0]     rwALPtr,
  input  logic [REFETCH_TYPE_WIDTH-1:0]          rwRefetchType,
  input  logic [ADDR_WIDTH-1:0]                  rwPC,
  input  logic [BRANCH_GLOBAL_HISTORY_WIDTH-1:0] rwBrHistory,
  input  logic [ACTIVE_LIST_INDEX_WIDTH-1:0]     alHeadPtr,
  input  logic                                   reqReady,
  input  logic                                   recoveryBusy,
  output logic                                   reqValid,
  output logic                                   reqFromRw,
  output logic [ADDR_WIDTH-1:0]                  reqPC,
  output logic [REFETCH_TYPE_WIDTH-1:0]          reqRefetchType,
  output logic [BRANCH_GLOBAL_HISTORY_WIDTH-1:0] reqBrHistory,
  output logic [ACTIVE_LIST_INDEX_WIDTH-1:0]     reqALPtr,
  output logic [7:0]                             dropCount
);

  RecoveryArbState r_state;
  RecoveryReq      r_hold;
  RecoveryReq      r_pend;
  logic            r_pendValid;
  logic            r_busyPrev;
  logic [7:0]      r_dropCount;

  RecoveryReq w_commitReq;
  RecoveryReq w_rwReq;
  logic       w_rwOlder;
  logic       w_busyFall;
  logic       w_rwAccept;
  logic       w_rwDrop;

  // A commit op sits at the ActiveList head, so it carries the head ptr.
  assign w_commitReq = '{
    fromRw:      1'b0,
    refetchType: commitRefetchType,
    pc:          commitPC,
    brHistory:   commitBrHistory,
    alPtr:       alHeadPtr
  };

  assign w_rwReq = '{
    fromRw:      1'b1,
    refetchType: rwRefetchType,
    pc:          rwPC,
    brHistory:   rwBrHistory,
    alPtr:       rwALPtr
  };

  recovery_age_compare u_age (
    .aPtr    (rwALPtr),
    .bPtr    (r_hold.alPtr),
    .headPtr (alHeadPtr),
    .aOlder  (w_rwOlder)
  );

  assign w_busyFall = r_busyPrev & ~recoveryBusy;

  assign w_rwAccept = rwReqValid & ~commitReqValid &
    ((r_state == RECOVERY_ARB_IDLE) |
     ((r_state == RECOVERY_ARB_HOLD) &
      r_hold.fromRw & w_rwOlder));

  assign w_rwDrop = rwReqValid & ~w_rwAccept;

  assign reqValid       = (r_state == RECOVERY_ARB_HOLD);
  assign reqFromRw      = r_hold.fromRw;
  assign reqPC          = r_hold.pc;
  assign reqRefetchType = r_hold.refetchType;
  assign reqBrHistory   = r_hold.brHistory;
  assign reqALPtr       = r_hold.alPtr;
  assign dropCount      = r_dropCount;

  // Arbitration FSM with hold register, pending slot and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RECOVERY_ARB_IDLE;
      r_hold      <= '0;
      r_pend      <= '0;
      r_pendValid <= 1'b0;
      r_busyPrev  <= 1'b0;
      r_dropCount <= '0;
    end else begin
      r_busyPrev <= recoveryBusy;
      if (w_rwDrop && r_dropCount != DROP_COUNT_MAX)
        r_dropCount <= r_dropCount + 8'd1;
      unique case (r_state)
        RECOVERY_ARB_IDLE: begin
          if (commitReqValid) begin
            r_hold  <= w_commitReq;
            r_state <= RECOVERY_ARB_HOLD;
          end else if (rwReqValid) begin
            r_hold  <= w_rwReq;
            r_state <= RECOVERY_ARB_HOLD;
          end
        end
        RECOVERY_ARB_HOLD: begin
          if (commitReqValid)
            r_hold <= w_commitReq;
          else if (w_rwAccept)
            r_hold <= w_rwReq;
          else if (reqReady)
            r_state <= RECOVERY_ARB_ISSUED;
        end
        RECOVERY_ARB_ISSUED: begin
          if (w_busyFall) begin
            r_pendValid <= 1'b0;
            if (commitReqValid) begin
              r_hold  <= w_commitReq;
              r_state <= RECOVERY_ARB_HOLD;
            end else if (r_pendValid) begin
              r_hold  <= r_pend;
              r_state <= RECOVERY_ARB_HOLD;
            end else begin
              r_state <= RECOVERY_ARB_IDLE;
            end
          end else if (commitReqValid) begin
            r_pend      <= w_commitReq;
            r_pendValid <= 1'b1;
          end
        end
        default: r_state <= RECOVERY_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_request_arbiter.sv
// Bench for recovery_request_arbiter: directed table,
// random run against a reference model, reset/saturation.
module tb_recovery_request_arbiter;

  logic        clk;
  logic        rst;
  logic        commitReqValid;
  logic [2:0]  commitRefetchType;
  logic [31:0] commitPC;
  logic [9:0]  commitBrHistory;
  logic        rwReqValid;
  logic [5:0]  rwALPtr;
  logic [2:0]  rwRefetchType;
  logic [31:0] rwPC;
  logic [9:0]  rwBrHistory;
  logic [5:0]  alHeadPtr;
  logic        reqReady;
  logic        recoveryBusy;
  logic        reqValid;
  logic        reqFromRw;
  logic [31:0] reqPC;
  logic [2:0]  reqRefetchType;
  logic [9:0]  reqBrHistory;
  logic [5:0]  reqALPtr;
  logic [7:0]  dropCount;

  recovery_request_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .commitReqValid    (commitReqValid),
    .commitRefetchType (commitRefetchType),
    .commitPC          (commitPC),
    .commitBrHistory   (commitBrHistory),
    .rwReqValid        (rwReqValid),
    .rwALPtr           (rwALPtr),
    .rwRefetchType     (rwRefetchType),
    .rwPC              (rwPC),
    .rwBrHistory       (rwBrHistory),
    .alHeadPtr         (alHeadPtr),
    .reqReady          (reqReady),
    .recoveryBusy      (recoveryBusy),
    .reqValid          (reqValid),
    .reqFromRw         (reqFromRw),
    .reqPC             (reqPC),
    .reqRefetchType    (reqRefetchType),
    .reqBrHistory      (reqBrHistory),
    .reqALPtr          (reqALPtr),
    .dropCount         (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          cv;
    logic [31:0] cpc;
    bit          rv;
    logic [5:0]  rp;
    logic [31:0] rpc;
    logic [5:0]  hd;
    bit          rdy;
    bit          busy;
    bit          xchk;
    logic [5:0]  xptr;
    bit          ev;
    bit          efr;
    logic [31:0] epc;
    logic [5:0]  eptr;
    int          ed;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    bit          fr;
    logic [31:0] pc;
    logic [2:0]  rt;
    logic [9:0]  bh;
    int          ptr;
  } req_t;

  bit   m_holding;
  bit   m_issued;
  req_t m_hold;
  req_t m_pend[$];
  bit   m_prevBusy;
  int   m_drops;

  function automatic int age(input int p, input int h);
    return ((p - h) % 64 + 64) % 64;
  endfunction

  function automatic void model_reset();
    m_holding  = 0;
    m_issued   = 0;
    m_hold     = '{0, 0, 0, 0, 0};
    m_pend.delete();
    m_prevBusy = 0;
    m_drops    = 0;
  endfunction

  function automatic void model_step();
    req_t c;
    req_t r;
    bit   rwLost;
    bit   replaced;
    c = '{0, commitPC, commitRefetchType,
          commitBrHistory, int'(alHeadPtr)};
    r = '{1, rwPC, rwRefetchType,
          rwBrHistory, int'(rwALPtr)};
    rwLost = rwReqValid;
    if (m_holding) begin
      replaced = 0;
      if (commitReqValid) begin
        m_hold   = c;
        replaced = 1;
      end else if (rwReqValid && m_hold.fr &&
                   age(r.ptr, int'(alHeadPtr)) <
                   age(m_hold.ptr, int'(alHeadPtr))) begin
        m_hold   = r;
        replaced = 1;
        rwLost   = 0;
      end
      if (reqReady && !replaced) begin
        m_holding = 0;
        m_issued  = 1;
      end
    end else if (m_issued) begin
      if (commitReqValid) begin
        m_pend.delete();
        m_pend.push_back(c);
      end
      if (m_prevBusy && !recoveryBusy) begin
        m_issued = 0;
        if (m_pend.size() > 0) begin
          m_hold    = m_pend.pop_front();
          m_holding = 1;
        end
        m_pend.delete();
      end
    end else begin
      if (commitReqValid) begin
        m_hold    = c;
        m_holding = 1;
      end else if (rwReqValid) begin
        m_hold    = r;
        m_holding = 1;
        rwLost    = 0;
      end
    end
    m_prevBusy = recoveryBusy;
    if (rwLost && m_drops < 255) m_drops++;
  endfunction

  task automatic idle_inputs();
    commitReqValid    = 0;
    commitRefetchType = 3'd1;
    commitPC          = 0;
    commitBrHistory   = 10'h011;
    rwReqValid        = 0;
    rwALPtr           = 0;
    rwRefetchType     = 3'd2;
    rwPC              = 0;
    rwBrHistory       = 10'h022;
    alHeadPtr         = 0;
    reqReady          = 0;
    recoveryBusy      = 0;
  endtask

  task automatic addv(
    input bit rs, input bit cv, input logic [31:0] cpc,
    input bit rv, input logic [5:0] rp,
    input logic [31:0] rpc, input logic [5:0] hd,
    input bit rdy, input bit busy,
    input bit xc, input logic [5:0] xp,
    input bit ev, input bit efr, input logic [31:0] epc,
    input logic [5:0] eptr, input int ed);
    vec_t v;
    v = '{rs, cv, cpc, rv, rp, rpc, hd, rdy, busy,
          xc, xp, ev, efr, epc, eptr, ed};
    vecs.push_back(v);
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      commitReqValid = vecs[i].cv;
      commitPC       = vecs[i].cpc;
      rwReqValid     = vecs[i].rv;
      rwALPtr        = vecs[i].rp;
      rwPC           = vecs[i].rpc;
      alHeadPtr      = vecs[i].hd;
      reqReady       = vecs[i].rdy;
      recoveryBusy   = vecs[i].busy;
      #1;
      if (vecs[i].xchk) begin
        chk($sformatf("xfer_valid[%0d]", i),
            64'(reqValid & reqReady), 64'd1);
        chk($sformatf("xfer_ptr[%0d]", i),
            64'(reqALPtr), 64'(vecs[i].xptr));
      end
      @(posedge clk);
      #1;
      chk($sformatf("valid[%0d]", i),
          64'(reqValid), 64'(vecs[i].ev));
      chk($sformatf("drop[%0d]", i),
          64'(dropCount), 64'(vecs[i].ed));
      if (vecs[i].ev || vecs[i].rst) begin
        chk($sformatf("fromRw[%0d]", i),
            64'(reqFromRw), 64'(vecs[i].efr));
        chk($sformatf("pc[%0d]", i),
            64'(reqPC), 64'(vecs[i].epc));
        chk($sformatf("ptr[%0d]", i),
            64'(reqALPtr), 64'(vecs[i].eptr));
      end
      @(negedge clk);
    end
    rst = 0;
  endtask

  task automatic rand_tick();
    @(posedge clk);
    model_step();
    #1;
    chk("rnd_valid", 64'(reqValid), 64'(m_holding));
    chk("rnd_drop", 64'(dropCount), 64'(m_drops));
    if (m_holding) begin
      chk("rnd_fromRw", 64'(reqFromRw), 64'(m_hold.fr));
      chk("rnd_pc", 64'(reqPC), 64'(m_hold.pc));
      chk("rnd_rt", 64'(reqRefetchType), 64'(m_hold.rt));
      chk("rnd_bh", 64'(reqBrHistory), 64'(m_hold.bh));
      chk("rnd_ptr", 64'(reqALPtr), 64'(m_hold.ptr));
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #12;
    chk("reset_valid", 64'(reqValid), 64'd0);
    chk("reset_drop", 64'(dropCount), 64'd0);
    chk("reset_pc", 64'(reqPC), 64'd0);
    @(negedge clk);

    // rs cv cpc rv rp rpc hd rdy busy xc xp ev efr epc eptr ed
    addv(1,0,0,      0,0, 0,    0, 0,0, 0,0, 0,0,0,      0, 0);
    addv(0,0,0,      1,5, 'h500,2, 0,0, 0,0, 1,1,'h500,  5, 0);
    addv(0,0,0,      1,3, 'h300,2, 0,0, 0,0, 1,1,'h300,  3, 0);
    addv(0,0,0,      1,7, 'h700,2, 0,0, 0,0, 1,1,'h300,  3, 1);
    addv(0,1,'h1000, 1,2, 'h200,2, 0,0, 0,0, 1,0,'h1000, 2, 2);
    addv(0,0,0,      0,0, 0,    2, 1,0, 1,2, 0,0,0,      0, 2);
    addv(0,0,0,      0,0, 0,    2, 0,1, 0,0, 0,0,0,      0, 2);
    addv(0,0,0,      0,0, 0,    2, 0,0, 0,0, 0,0,0,      0, 2);
    addv(0,0,0,      1,9, 'h900,2, 0,0, 0,0, 1,1,'h900,  9, 2);
    addv(0,1,'h1100, 0,0, 0,    2, 1,0, 1,9, 1,0,'h1100, 2, 2);
    addv(0,0,0,      0,0, 0,    2, 1,0, 0,0, 0,0,0,      0, 2);
    addv(0,0,0,      0,0, 0,    2, 0,1, 0,0, 0,0,0,      0, 2);
    addv(0,1,'h2000, 1,4, 'h400,2, 0,1, 0,0, 0,0,0,      0, 3);
    addv(0,0,0,      0,0, 0,    2, 0,0, 0,0, 1,0,'h2000, 2, 3);
    addv(0,0,0,      0,0, 0,    2, 1,0, 0,0, 0,0,0,      0, 3);
    addv(0,0,0,      0,0, 0,    2, 0,1, 0,0, 0,0,0,      0, 3);
    addv(0,0,0,      0,0, 0,    2, 0,0, 0,0, 0,0,0,      0, 3);
    addv(0,1,'h3000, 1,4, 'h400,2, 0,0, 0,0, 1,0,'h3000, 2, 4);
    addv(1,0,0,      0,0, 0,    0, 0,0, 0,0, 0,0,0,      0, 0);
    addv(0,0,0,      1,62,'h620,60,0,0, 0,0, 1,1,'h620, 62, 0);
    addv(0,0,0,      1,1, 'h010,60,0,0, 0,0, 1,1,'h620, 62, 1);
    addv(0,0,0,      1,61,'h610,60,0,0, 0,0, 1,1,'h610, 61, 1);
    addv(0,0,0,      1,61,'h611,60,0,0, 0,0, 1,1,'h610, 61, 2);
    addv(0,1,'h4000, 0,0, 0,    60,0,0, 0,0, 1,0,'h4000,60, 2);
    addv(0,0,0,      1,60,'h600,60,0,0, 0,0, 1,0,'h4000,60, 3);
    addv(0,0,0,      1,59,'h590,60,1,0, 1,60,0,0,0,      0, 4);
    run_table();

    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      commitReqValid    = ($urandom_range(0, 4) == 0);
      commitRefetchType = 3'($urandom);
      commitPC          = $urandom;
      commitBrHistory   = 10'($urandom);
      rwReqValid        = ($urandom_range(0, 1) == 0);
      rwALPtr           = 6'($urandom);
      rwRefetchType     = 3'($urandom);
      rwPC              = $urandom;
      rwBrHistory       = 10'($urandom);
      if ($urandom_range(0, 7) == 0)
        alHeadPtr = 6'($urandom);
      reqReady = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0)
        recoveryBusy = ~recoveryBusy;
      rand_tick();
    end

    idle_inputs();
    rwReqValid = 1;
    rwALPtr    = 6'd10;
    rwPC       = 32'hA0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("async_valid", 64'(reqValid), 64'd0);
    chk("async_drop", 64'(dropCount), 64'd0);
    chk("async_ptr", 64'(reqALPtr), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 64'(reqValid), 64'd0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("sat_accept", 64'(reqALPtr), 64'd10);
    chk("sat_start", 64'(dropCount), 64'd0);
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (k == 254)
        chk("sat_254", 64'(dropCount), 64'd254);
      if (k == 255)
        chk("sat_255", 64'(dropCount), 64'd255);
    end
    chk("sat_300", 64'(dropCount), 64'd255);
    chk("sat_valid", 64'(reqValid), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
